seletor_clock_div: RTL

Parametrised, glitch-free clock-rate selector and divider driving the processor clock (`clock_saida`). It derives N_SEL selectable rates from the single board clock with an internal counter, so no external divided clocks are needed. It accepts a one-hot rate select and switches rate only at a period boundary. It also provides a single-step mode for debugging.

---
 rtl/seletor_clock_div_if.sv | 22 ++
 rtl/seletor_clock_div.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/seletor_clock_div_if.sv
// rtl/seletor_clock_div_if.sv - rate-select, step and divided-clock signal bundle
interface seletor_clock_div_if #(
  parameter int N_SEL = 4
) ();
  logic [N_SEL-1:0] sel;
  logic             step_mode;
  logic             step;
  logic             clock_saida;
  logic             clock_en;
  logic             sel_valid;
  logic [N_SEL-1:0] cur_sel;

  modport master (
    output sel, step_mode, step,
    input  clock_saida, clock_en, sel_valid, cur_sel
  );

  modport slave (
    input  sel, step_mode, step,
    output clock_saida, clock_en, sel_valid, cur_sel
  );
endinterface

// File: rtl/seletor_clock_div.sv
// rtl/seletor_clock_div.sv - glitch-free selectable clock divider with single-step mode
module seletor_clock_div #(
  parameter int                     N_SEL        = 4,
  parameter int                     CNT_W        = 25,
  parameter logic [N_SEL*CNT_W-1:0] HALF_PERIODS = {25'd1, 25'd25, 25'd25000, 25'd25000000},
  parameter int                     STEP_LEN     = 1
) (
  input logic               clock,
  input logic               reset,
  seletor_clock_div_if.slave bus
);

  localparam logic [CNT_W-1:0] STEP_CNT = CNT_W'(STEP_LEN - 1);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, STEP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_out_q, clk_out_d;
  logic             clk_en_q, clk_en_d;
  logic [N_SEL-1:0] cur_sel_q, cur_sel_d;
  logic [N_SEL-1:0] sel_q;
  logic             sel_valid_q;
  logic             step_s1_q, step_s2_q, step_s3_q, step_rise_q;
  logic [CNT_W-1:0] h_cur, h_new;

  // Half period selected by a one-hot vector; a zero entry behaves as 1.
  function automatic logic [CNT_W-1:0] half_of(input logic [N_SEL-1:0] oh);
    logic [CNT_W-1:0] h;
    h = '0;
    for (int i = 0; i < N_SEL; i++) begin
      if (oh[i]) h = h | HALF_PERIODS[i*CNT_W +: CNT_W];
    end
    if (h == '0) h = CNT_W'(1);
    return h;
  endfunction

  assign h_cur = half_of(cur_sel_q);
  assign h_new = half_of(sel_q);

  // Register the rate select and its one-hot check; the FSM sees only these.
  always_ff @(posedge clock) begin
    if (reset) begin
      sel_q       <= '0;
      sel_valid_q <= 1'b0;
    end else begin
      sel_q       <= bus.sel;
      sel_valid_q <= $onehot(bus.sel);
    end
  end

  // Two-flop synchroniser for the button, then an edge flop; the rise pulse is registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      step_s1_q   <= 1'b0;
      step_s2_q   <= 1'b0;
      step_s3_q   <= 1'b0;
      step_rise_q <= 1'b0;
    end else begin
      step_s1_q   <= bus.step;
      step_s2_q   <= step_s1_q;
      step_s3_q   <= step_s2_q;
      step_rise_q <= step_s2_q & ~step_s3_q;
    end
  end

  // FSM state, half-period counter and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      clk_out_q <= 1'b0;
      clk_en_q  <= 1'b0;
      cur_sel_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      clk_out_q <= clk_out_d;
      clk_en_q  <= clk_en_d;
      cur_sel_q <= cur_sel_d;
    end
  end

  // Next state: rate, mode and stop decisions are taken only at the end of LOW.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clk_out_d = clk_out_q;
    clk_en_d  = 1'b0;
    cur_sel_d = cur_sel_q;
    unique case (state_q)
      IDLE: begin
        clk_out_d = 1'b0;
        if (!bus.step_mode && sel_valid_q) begin
          cur_sel_d = sel_q;
          cnt_d     = h_new - CNT_W'(1);
          clk_out_d = 1'b1;
          clk_en_d  = 1'b1;
          state_d   = HIGH;
        end else if (bus.step_mode && step_rise_q) begin
          cnt_d     = STEP_CNT;
          clk_out_d = 1'b1;
          clk_en_d  = 1'b1;
          state_d   = STEP;
        end
      end
      HIGH: begin
        if (cnt_q == '0) begin
          clk_out_d = 1'b0;
          cnt_d     = h_cur - CNT_W'(1);
          state_d   = LOW;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      LOW: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (bus.step_mode || !sel_valid_q) begin
          cur_sel_d = '0;
          clk_out_d = 1'b0;
          state_d   = IDLE;
        end else begin
          cur_sel_d = sel_q;
          cnt_d     = h_new - CNT_W'(1);
          clk_out_d = 1'b1;
          clk_en_d  = 1'b1;
          state_d   = HIGH;
        end
      end
      STEP: begin
        if (cnt_q == '0) begin
          clk_out_d = 1'b0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.clock_saida = clk_out_q;
  assign bus.clock_en    = clk_en_q;
  assign bus.sel_valid   = sel_valid_q;
  assign bus.cur_sel     = cur_sel_q;

endmodule
